// File: rtl/irq_capture_if.sv
// Internal CPU register bus: word-addressed, single-cycle writes, combinational reads.
interface intbus_interf;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, wr, wdata, input rdata);
  modport slave  (input addr, wr, wdata, output rdata);
endinterface

// File: rtl/irq_capture.sv
// CPU-side interrupt receiver: synchronises irq_in, detects events by polarity/mode,
// tracks pending/overrun/stuck and measures count, ack latency, pulse width and interval.
module irq_capture #(
  parameter logic [31:0] BASEADDR    = 32'd0,
  parameter int          SYNC_STAGES = 2,
  parameter int          RELEASE_TMO = 16
) (
  input  logic        clk,
  input  logic        rst,
  intbus_interf.slave bus,
  input  logic        irq_in,
  output logic        irq_pend
);

  localparam logic [31:0] ID_VALUE = 32'h4952_4331;
  localparam logic [31:0] TMO_LAST = 32'(RELEASE_TMO - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ACKED} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   cfg_en, cfg_sens, cfg_pol;
  logic                   act, act_prev, pending, overrun, stuck, have_prev;
  logic [31:0]            count, latency, width, interval;
  logic [31:0]            lat_cnt, width_cnt, ivl_cnt, rel_cnt;
  logic [31:0]            offset;
  logic                   cfg_wr, ack, clr, evt;
  logic                   take_evt, take_ack, latch_width, set_stuck;
  logic                   unused_wdata;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ack and clr_stat act in the cycle of the CFG write and always read back as 0.
  assign offset       = bus.addr - BASEADDR;
  assign cfg_wr       = bus.wr && (offset == 32'd0);
  assign ack          = cfg_wr && bus.wdata[3];
  assign clr          = cfg_wr && bus.wdata[4];
  assign act          = sync[SYNC_STAGES-1] ^ cfg_pol;
  assign evt          = cfg_en && act && !act_prev;
  assign irq_pend     = pending;
  assign unused_wdata = ^bus.wdata[31:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    take_evt    = 1'b0;
    take_ack    = 1'b0;
    latch_width = 1'b0;
    set_stuck   = 1'b0;
    if (!cfg_en) begin
      state_nxt = IDLE;
    end else begin
      take_ack = ack && pending;
      case (state)
        IDLE: begin
          if (evt) begin
            take_evt  = 1'b1;
            state_nxt = ACTIVE;
          end
        end
        ACTIVE: begin
          if (!cfg_sens) begin
            if (!act) begin
              latch_width = 1'b1;
              state_nxt   = IDLE;
            end
          end else if (take_ack) begin
            state_nxt = ACKED;
          end
        end
        ACKED: begin
          if (!act) begin
            state_nxt = IDLE;
          end else if (rel_cnt == TMO_LAST) begin
            set_stuck = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // act_prev always follows act, so enabling on an already-active line or leaving
  // ACKED on a stuck line cannot produce a spurious event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      act_prev  <= 1'b0;
      cfg_en    <= 1'b0;
      cfg_sens  <= 1'b0;
      cfg_pol   <= 1'b0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      stuck     <= 1'b0;
      have_prev <= 1'b0;
      count     <= '0;
      latency   <= '0;
      width     <= '0;
      interval  <= '0;
      lat_cnt   <= '0;
      width_cnt <= '0;
      ivl_cnt   <= '0;
      rel_cnt   <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], irq_in};
      act_prev <= act;

      if (cfg_wr) begin
        cfg_en   <= bus.wdata[0];
        cfg_sens <= bus.wdata[1];
        cfg_pol  <= bus.wdata[2];
      end

      if (!cfg_en)       pending <= 1'b0;
      else if (take_evt) pending <= 1'b1;
      else if (take_ack) pending <= 1'b0;

      lat_cnt <= take_evt ? 32'd0 : sat_inc(lat_cnt);
      ivl_cnt <= take_evt ? 32'd1 : sat_inc(ivl_cnt);
      rel_cnt <= (state == ACKED) ? rel_cnt + 32'd1 : 32'd0;

      if (take_evt)                   width_cnt <= 32'd1;
      else if (state == ACTIVE && act) width_cnt <= sat_inc(width_cnt);

      // Statistics clear wins over everything except an event landing in the same cycle.
      if (clr) begin
        count     <= take_evt ? 32'd1 : 32'd0;
        overrun   <= 1'b0;
        stuck     <= 1'b0;
        latency   <= '0;
        width     <= '0;
        interval  <= '0;
        have_prev <= take_evt;
      end else begin
        if (take_evt) begin
          count     <= count + 32'd1;
          interval  <= have_prev ? ivl_cnt : 32'd0;
          have_prev <= 1'b1;
          if (pending && !take_ack) overrun <= 1'b1;
        end
        if (take_ack)    latency <= lat_cnt;
        if (latch_width) width   <= width_cnt;
        if (set_stuck)   stuck   <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (offset)
      32'd0:   bus.rdata = {29'd0, cfg_pol, cfg_sens, cfg_en};
      32'd1:   bus.rdata = {28'd0, act, stuck, overrun, pending};
      32'd2:   bus.rdata = count;
      32'd3:   bus.rdata = latency;
      32'd4:   bus.rdata = width;
      32'd5:   bus.rdata = interval;
      32'd6:   bus.rdata = ID_VALUE;
      default: bus.rdata = '0;
    endcase
  end

endmodule
